// File: rtl/branch_predictor_bht.sv
// Bimodal branch history table: 2-bit saturating counters indexed by PC, registered
// lookup, training from the EX resolver, a mispredict pulse, and saturating statistics.
module branch_predictor_bht #(
    parameter int ENTRIES = 64,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lookup_valid,
    input  logic [PC_W-1:0]  lookup_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_is_branch,
    input  logic             upd_taken,
    input  logic             upd_pred,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [1:0]       table_q [ENTRIES];
    logic [1:0]       table_d [ENTRIES];
    logic             pred_valid_q, pred_valid_d;
    logic             pred_taken_q, pred_taken_d;
    logic             mispredict_q, mispredict_d;
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] mispred_count_q, mispred_count_d;

    logic [IDX_W-1:0] lk_idx_s;
    logic [IDX_W-1:0] upd_idx_s;
    logic             upd_fire_s;
    logic             unused_pc_s;

    function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic taken);
        logic [1:0] n;
        if (taken) begin
            n = (c == 2'b11) ? 2'b11 : c + 2'b01;
        end else begin
            n = (c == 2'b00) ? 2'b00 : c - 2'b01;
        end
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] n;
        if (v == {CNT_W{1'b1}}) begin
            n = v;
        end else begin
            n = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return n;
    endfunction

    assign lk_idx_s    = lookup_pc[IDX_W+1:2];
    assign upd_idx_s   = upd_pc[IDX_W+1:2];
    assign upd_fire_s  = upd_valid & upd_is_branch;
    assign unused_pc_s = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0],
                           upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};

    // Next-state: table training, registered lookup result, mispredict and stats.
    always_comb begin
        table_d = table_q;
        if (upd_fire_s) begin
            table_d[upd_idx_s] = ctr_next(table_q[upd_idx_s], upd_taken);
        end else begin
            table_d = table_q;
        end

        pred_valid_d = lookup_valid;
        if (lookup_valid) begin
            // Reads the pre-update value, so a same-cycle update is not forwarded.
            pred_taken_d = table_q[lk_idx_s][1];
        end else begin
            pred_taken_d = 1'b0;
        end

        mispredict_d = upd_fire_s & (upd_taken ^ upd_pred);

        if (upd_fire_s) begin
            branch_count_d = sat_inc(branch_count_q);
        end else begin
            branch_count_d = branch_count_q;
        end

        if (mispredict_d) begin
            mispred_count_d = sat_inc(mispred_count_q);
        end else begin
            mispred_count_d = mispred_count_q;
        end
    end

    // State registers; reset leaves every counter weakly not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= 2'b01;
            end
            pred_valid_q    <= 1'b0;
            pred_taken_q    <= 1'b0;
            mispredict_q    <= 1'b0;
            branch_count_q  <= {CNT_W{1'b0}};
            mispred_count_q <= {CNT_W{1'b0}};
        end else begin
            table_q         <= table_d;
            pred_valid_q    <= pred_valid_d;
            pred_taken_q    <= pred_taken_d;
            mispredict_q    <= mispredict_d;
            branch_count_q  <= branch_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign pred_valid    = pred_valid_q;
    assign pred_taken    = pred_taken_q;
    assign mispredict    = mispredict_q;
    assign branch_count  = branch_count_q;
    assign mispred_count = mispred_count_q;

endmodule
